// File: rtl/mag_stats.sv
// mag_stats: windowed average / peak of 8-bit magnitude samples plus a
// hysteresis threshold alarm with a saturating event counter.
// Optional feature macro: MAG_STATS_PEAK_EN builds the peak tracker; when it
// is undefined no peak storage exists and peak is tied to zero.
// All outputs come straight from flops.
module mag_stats #(
  parameter int unsigned WIN_LOG2  = 3,
  parameter logic [7:0]  THRESH_HI = 8'd200,
  parameter logic [7:0]  THRESH_LO = 8'd150
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  input  logic [7:0] in_mag,
  input  logic       clear,
  output logic       out_valid,
  output logic [7:0] avg,
  output logic [7:0] peak,
  output logic       alarm,
  output logic [7:0] event_cnt
);

  localparam int unsigned ACC_W = 8 + WIN_LOG2;
  localparam logic [WIN_LOG2-1:0] CNT_ONE = WIN_LOG2'(1);

  typedef enum logic {
    IDLE  = 1'b0,
    ALARM = 1'b1
  } state_t;

  logic                accept;
  logic                last;
  logic [ACC_W-1:0]    acc_sum;

  logic [WIN_LOG2-1:0] cnt_q,       cnt_d;
  logic [ACC_W-1:0]    acc_q,       acc_d;
  logic [7:0]          avg_q,       avg_d;
  logic                out_valid_q, out_valid_d;
  state_t              state_q,     state_d;
  logic [7:0]          event_cnt_q, event_cnt_d;

  // A sample is taken only when valid and not being cleared.
  always_comb begin
    accept  = in_valid & ~clear;
    last    = (cnt_q == '1);
    acc_sum = acc_q + {{WIN_LOG2{1'b0}}, in_mag};
  end

  // Window counter, accumulator and average update.
  always_comb begin
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    avg_d       = avg_q;
    out_valid_d = 1'b0;
    if (clear) begin
      cnt_d = '0;
      acc_d = '0;
      avg_d = '0;
    end else if (accept) begin
      cnt_d = cnt_q + CNT_ONE;
      if (last) begin
        avg_d       = acc_sum[WIN_LOG2 +: 8];
        acc_d       = '0;
        out_valid_d = 1'b1;
      end else begin
        acc_d = acc_sum;
      end
    end
  end

  // Hysteresis alarm next-state and rising-edge event counting.
  always_comb begin
    state_d     = state_q;
    event_cnt_d = event_cnt_q;
    if (clear) begin
      state_d     = IDLE;
      event_cnt_d = '0;
    end else if (accept) begin
      case (state_q)
        IDLE: begin
          if (in_mag >= THRESH_HI) begin
            state_d = ALARM;
            if (event_cnt_q != '1) begin
              event_cnt_d = event_cnt_q + 8'd1;
            end
          end
        end
        ALARM: begin
          if (in_mag <= THRESH_LO) begin
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Statistics and alarm state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      acc_q       <= '0;
      avg_q       <= '0;
      out_valid_q <= 1'b0;
      state_q     <= IDLE;
      event_cnt_q <= '0;
    end else begin
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      avg_q       <= avg_d;
      out_valid_q <= out_valid_d;
      state_q     <= state_d;
      event_cnt_q <= event_cnt_d;
    end
  end

`ifdef MAG_STATS_PEAK_EN
  logic [7:0] run_max_q, run_max_d;
  logic [7:0] peak_q,    peak_d;
  logic [7:0] max_now;

  // Running maximum; handed to peak and restarted on the last sample.
  always_comb begin
    max_now   = (in_mag > run_max_q) ? in_mag : run_max_q;
    run_max_d = run_max_q;
    peak_d    = peak_q;
    if (clear) begin
      run_max_d = '0;
      peak_d    = '0;
    end else if (accept) begin
      if (last) begin
        peak_d    = max_now;
        run_max_d = '0;
      end else begin
        run_max_d = max_now;
      end
    end
  end

  // Peak tracker registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_max_q <= '0;
      peak_q    <= '0;
    end else begin
      run_max_q <= run_max_d;
      peak_q    <= peak_d;
    end
  end

  assign peak = peak_q;
`else
  assign peak = '0;
`endif

  assign out_valid = out_valid_q;
  assign avg       = avg_q;
  assign alarm     = (state_q == ALARM);
  assign event_cnt = event_cnt_q;

endmodule

// File: tb/tb_mag_stats.sv
module tb_mag_stats;

`ifdef MAG_STATS_PEAK_EN
  localparam bit PEAK_EN = 1'b1;
`else
  localparam bit PEAK_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic [7:0] in_mag;
  logic       clear;
  logic       out_valid;
  logic [7:0] avg;
  logic [7:0] peak;
  logic       alarm;
  logic [7:0] event_cnt;

  int tests = 0;
  int fails = 0;
  bit done  = 1'b0;

  mag_stats dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_mag    (in_mag),
    .clear     (clear),
    .out_valid (out_valid),
    .avg       (avg),
    .peak      (peak),
    .alarm     (alarm),
    .event_cnt (event_cnt)
  );

  always #5 clk = ~clk;

  function automatic int pk(input int v);
    return PEAK_EN ? v : 0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input logic v, input logic [7:0] m, input logic c);
    @(negedge clk);
    in_valid = v;
    in_mag   = m;
    clear    = c;
    @(posedge clk);
    #1;
  endtask

  int alarm_exp[6] = '{1, 1, 1, 0, 1, 0};
  int seq3[6]      = '{210, 180, 160, 150, 210, 100};

  initial begin
    #1000000;
    if (!done) begin
      fails++;
      $error("FAIL timeout: bench did not complete");
      $finish;
    end
  end

  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_mag   = '0;
    clear    = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_avg", avg, 0);
    chk("rst_peak", peak, 0);
    chk("rst_ov", out_valid, 0);
    chk("rst_alarm", alarm, 0);
    chk("rst_evt", event_cnt, 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) begin
      step(1'b1, 8'd5, 1'b0);
      if (i == 6) chk("s1_ov_early", out_valid, 0);
    end
    chk("s1_avg", avg, 5);
    chk("s1_peak", peak, pk(5));
    chk("s1_ov", out_valid, 1);
    step(1'b0, 8'd77, 1'b0);
    chk("s1_ov_pulse", out_valid, 0);
    chk("s1_avg_hold", avg, 5);

    for (int i = 0; i < 8; i++) begin
      step(1'b1, 8'(i), 1'b0);
      if (i == 3) begin
        step(1'b0, 8'd200, 1'b0);
        chk("s2_gap_ov", out_valid, 0);
      end
    end
    chk("s2_avg", avg, 3);
    chk("s2_peak", peak, pk(7));
    chk("s2_ov", out_valid, 1);
    for (int i = 0; i < 8; i++) step(1'b1, 8'd255, 1'b0);
    chk("s2_avg255", avg, 255);
    chk("s2_peak255", peak, pk(255));
    chk("s2_ov255", out_valid, 1);
    chk("s2_alarm", alarm, 1);
    chk("s2_evt", event_cnt, 1);

    step(1'b0, 8'd0, 1'b1);
    chk("clr_avg", avg, 0);
    chk("clr_alarm", alarm, 0);
    chk("clr_evt", event_cnt, 0);
    for (int i = 0; i < 6; i++) begin
      step(1'b1, 8'(seq3[i]), 1'b0);
      chk("s3_alarm", alarm, alarm_exp[i]);
    end
    chk("s3_evt", event_cnt, 2);

    step(1'b0, 8'd0, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b1, 8'd200, 1'b0);
    chk("s4_alarm_pre", alarm, 1);
    chk("s4_evt_pre", event_cnt, 1);
    step(1'b1, 8'd99, 1'b1);
    chk("s4_clr_evt", event_cnt, 0);
    chk("s4_clr_alarm", alarm, 0);
    chk("s4_clr_avg", avg, 0);
    chk("s4_clr_peak", peak, 0);
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 8'd10, 1'b0);
      if (i == 6) chk("s4_ov_early", out_valid, 0);
    end
    chk("s4_avg", avg, 10);
    chk("s4_peak", peak, pk(10));
    chk("s4_ov", out_valid, 1);
    chk("s4_evt", event_cnt, 0);

    step(1'b1, 8'd210, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b1, 8'd50, 1'b0);
    chk("s5_pre_evt", event_cnt, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("s5_rst_avg", avg, 0);
    chk("s5_rst_peak", peak, 0);
    chk("s5_rst_alarm", alarm, 0);
    chk("s5_rst_evt", event_cnt, 0);
    chk("s5_rst_ov", out_valid, 0);
    @(negedge clk);
    in_valid = 1'b0;
    rst_n    = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 8'd20, 1'b0);
      if (i < 7) chk("s5_ov_early", out_valid, 0);
    end
    chk("s5_avg", avg, 20);
    chk("s5_peak", peak, pk(20));
    chk("s5_ov", out_valid, 1);

    for (int i = 0; i < 300; i++) begin
      step(1'b1, 8'd250, 1'b0);
      if (i == 253) chk("s6_evt254", event_cnt, 254);
      if (i == 254) chk("s6_evt255", event_cnt, 255);
      step(1'b1, 8'd0, 1'b0);
    end
    chk("s6_evt_sat", event_cnt, 255);
    chk("s6_avg", avg, 125);
    chk("s6_peak", peak, pk(250));
    chk("s6_alarm", alarm, 0);

    done = 1'b1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
